// File: rtl/result_demux4.sv
// Registered 1-to-4 result distributor: one producer stream steered into four
// single-entry channels with independent valid/ready. Option: RESULT_DEMUX4_BYPASS_EN.
module result_demux4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  chan_state_e      state      [4];
  chan_state_e      state_next [4];
  logic [WIDTH-1:0] data_q     [4];
  logic [WIDTH-1:0] out_mux    [4];
  logic [3:0]       addr_hot;
  logic [3:0]       bypass;
  logic [3:0]       load;
  logic             accept;

  always_comb begin
    addr_hot          = '0;
    addr_hot[in_addr] = 1'b1;
    in_ready = !flush && ((state[in_addr] == EMPTY) || out_ready[in_addr]);
    accept   = in_valid && in_ready;
  end

`ifdef RESULT_DEMUX4_BYPASS_EN
  // A beat for an empty channel whose consumer is ready passes straight through.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bypass[k] = addr_hot[k] && in_valid && !flush && out_ready[k] && (state[k] == EMPTY);
    end
  end
`else
  assign bypass = '0;
`endif

  assign load = addr_hot & {4{accept}} & ~bypass;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) state[k] <= EMPTY;
    end else begin
      for (int k = 0; k < 4; k++) state[k] <= state_next[k];
    end
  end

  // NOTE: payload registers carry no reset; out_valid masks them, so a reset
  // here would only cost flops and routing on the reset net.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (load[k]) data_q[k] <= in_data;
    end
  end

  // Next-state: a refill on the same edge as a pop keeps the channel FULL.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      state_next[k] = state[k];
      if (flush)                                    state_next[k] = EMPTY;
      else if (load[k])                             state_next[k] = FULL;
      else if ((state[k] == FULL) && out_ready[k])  state_next[k] = EMPTY;
    end
  end

  // Outputs are forced to zero whenever the channel is not presenting a beat.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = ((state[k] == FULL) && !flush) || bypass[k];
      out_mux[k]   = '0;
      if (out_valid[k]) out_mux[k] = bypass[k] ? in_data : data_q[k];
    end
  end

  assign out0 = out_mux[0];
  assign out1 = out_mux[1];
  assign out2 = out_mux[2];
  assign out3 = out_mux[3];

endmodule

// File: tb/tb_result_demux4.sv
// Directed bench for result_demux4 (default build, registered path) with a
// per-channel scoreboard of expected payloads.
module tb_result_demux4;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_addr;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out0, out1, out2, out3;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] sb [4][$];

  always #5 clk = ~clk;

  result_demux4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] chan_out(input int k);
    case (k)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return out3;
    endcase
  endfunction

  // One clock cycle: entered and left at posedge+1; checks at the falling edge.
  task automatic cycle(input logic v, input logic [1:0] a, input logic [WIDTH-1:0] d,
                       input logic [3:0] rdy, input logic fl,
                       input logic exp_ready, input logic [3:0] exp_valid, input string tag);
    logic [WIDTH-1:0] exp_d;
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    #4;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(exp_valid));
    for (int k = 0; k < 4; k++) begin
      if (exp_valid[k]) begin
        check($sformatf("%s_sb%0d_nonempty", tag, k), 32'(sb[k].size() != 0), 32'd1);
        if (sb[k].size() != 0) begin
          exp_d = sb[k][0];
          if (rdy[k]) void'(sb[k].pop_front());
          check($sformatf("%s_out%0d", tag, k), chan_out(k), exp_d);
        end
      end else begin
        check($sformatf("%s_out%0d_zero", tag, k), chan_out(k), 32'd0);
      end
    end
    if (fl) for (int k = 0; k < 4; k++) sb[k].delete();
    if (v && exp_ready) sb[a].push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
    out_ready = 4'b1111;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out0", out0, 32'd0);
    check("rst_out3", out3, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin stream, all consumers ready.
    cycle(1, 2'd0, 32'h11, 4'b1111, 0, 1, 4'b0000, "rr0");
    cycle(1, 2'd1, 32'h22, 4'b1111, 0, 1, 4'b0001, "rr1");
    cycle(1, 2'd2, 32'h33, 4'b1111, 0, 1, 4'b0010, "rr2");
    cycle(1, 2'd3, 32'h44, 4'b1111, 0, 1, 4'b0100, "rr3");
    cycle(0, 2'd0, 32'h0,  4'b1111, 0, 1, 4'b1000, "rr4");
    cycle(0, 2'd0, 32'h0,  4'b1111, 0, 1, 4'b0000, "rr5");

    // Isolated stall on channel 2.
    cycle(1, 2'd2, 32'hA, 4'b1011, 0, 1, 4'b0000, "st0");
    cycle(1, 2'd2, 32'hB, 4'b1011, 0, 0, 4'b0100, "st1");
    cycle(1, 2'd2, 32'hB, 4'b1011, 0, 0, 4'b0100, "st2");
    cycle(1, 2'd2, 32'hB, 4'b1111, 0, 1, 4'b0100, "st3");
    cycle(1, 2'd1, 32'hC, 4'b1111, 0, 1, 4'b0100, "st4");
    cycle(0, 2'd0, 32'h0, 4'b1111, 0, 1, 4'b0010, "st5");

    // Pop and refill on channel 0 with no bubble.
    cycle(1, 2'd0, 32'h5, 4'b1111, 0, 1, 4'b0000, "pr0");
    cycle(1, 2'd0, 32'h6, 4'b1111, 0, 1, 4'b0001, "pr1");
    cycle(0, 2'd0, 32'h0, 4'b1111, 0, 1, 4'b0001, "pr2");
    cycle(0, 2'd0, 32'h0, 4'b1111, 0, 1, 4'b0000, "pr3");

    // Flush with channels 0 and 3 full and a pending beat.
    cycle(1, 2'd0, 32'h70, 4'b0000, 0, 1, 4'b0000, "fl0");
    cycle(1, 2'd3, 32'h73, 4'b0000, 0, 1, 4'b0001, "fl1");
    cycle(1, 2'd1, 32'h99, 4'b1111, 1, 0, 4'b0000, "fl2");
    cycle(1, 2'd1, 32'h99, 4'b1111, 0, 1, 4'b0000, "fl3");
    cycle(0, 2'd0, 32'h0,  4'b1111, 0, 1, 4'b0010, "fl4");

    // Asynchronous reset between edges with channel 1 full.
    cycle(1, 2'd1, 32'hDEAD, 4'b0000, 0, 1, 4'b0000, "ar0");
    in_valid = 1'b0;
    #2;
    check("ar_pre_valid", 32'(out_valid), 32'b0010);
    check("ar_pre_out1", out1, 32'hDEAD);
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_out1", out1, 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    sb[1].delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(0, 2'd0, 32'h0, 4'b1111, 0, 1, 4'b0000, "ar1");

    for (int k = 0; k < 4; k++) check($sformatf("drain%0d", k), 32'(sb[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
